// File: rtl/fft_frame_sequencer.sv
// Frames a real sample stream into FFT packets and reports the strongest
// positive-frequency bin of each transformed frame.
module fft_frame_sequencer #(
    parameter int DATA_W     = 14,
    parameter int FFT_POINTS = 1024,
    parameter int PTS_W      = 11
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     sink_valid,
    output logic                     sink_sop,
    output logic                     sink_eop,
    output logic signed [DATA_W-1:0] sink_real,
    output logic signed [DATA_W-1:0] sink_imag,
    output logic                     inverse,
    output logic [PTS_W-1:0]         fft_pts,
    output logic [1:0]               sink_error,
    input  logic                     sink_ready,
    input  logic                     source_valid,
    input  logic                     source_sop,
    input  logic                     source_eop,
    input  logic signed [DATA_W-1:0] source_real,
    input  logic signed [DATA_W-1:0] source_imag,
    input  logic [1:0]               source_error,
    output logic                     source_ready,
    output logic [PTS_W-1:0]         peak_bin,
    output logic [DATA_W:0]          peak_mag,
    output logic                     peak_valid,
    output logic                     seq_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } sink_state_t;

    typedef enum logic [1:0] {
        S_WAIT_SOP,
        S_COLLECT,
        S_REPORT
    } src_state_t;

    localparam logic [PTS_W-1:0] LAST = PTS_W'(FFT_POINTS - 1);
    localparam logic [PTS_W-1:0] HALF = PTS_W'(FFT_POINTS / 2);

    sink_state_t      sink_state, sink_next;
    src_state_t       src_state, src_next;
    logic [PTS_W-1:0] in_cnt, in_cnt_n;
    logic             accept, eop_xfer, valid_n;
    logic [PTS_W-1:0] out_cnt;
    logic [PTS_W-1:0] max_bin;
    logic [DATA_W:0]  max_mag;
    logic [DATA_W:0]  mag;
    logic             beat, err, start, step, done, win;

    assign sink_imag  = '0;
    assign inverse    = 1'b0;
    assign sink_error = 2'b00;
    assign fft_pts    = PTS_W'(FFT_POINTS);

    // In DRAIN the frame is complete once in_cnt wraps; stop taking samples
    assign sample_ready = (sink_state == S_STREAM
                           || (sink_state == S_DRAIN && in_cnt != '0))
                          && (!sink_valid || sink_ready);
    assign accept   = sample_valid && sample_ready;
    assign eop_xfer = sink_valid && sink_eop && sink_ready;
    assign in_cnt_n = !accept ? in_cnt
                    : (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
    assign valid_n  = accept || (sink_valid && !sink_ready);

    always_comb begin
        sink_next = sink_state;
        unique case (sink_state)
            S_IDLE: begin
                if (enable) sink_next = S_STREAM;
            end
            S_STREAM: begin
                if (!enable) begin
                    if (in_cnt_n != '0 || valid_n) sink_next = S_DRAIN;
                    else                          sink_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (enable)
                    sink_next = S_STREAM;
                else if (eop_xfer || (in_cnt == '0 && !sink_valid))
                    sink_next = S_IDLE;
            end
            default: sink_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sink_state <= S_IDLE;
            in_cnt     <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            sink_real  <= '0;
        end else begin
            sink_state <= sink_next;
            in_cnt     <= in_cnt_n;
            if (accept) begin
                sink_valid <= 1'b1;
                sink_real  <= sample_in;
                sink_sop   <= (in_cnt == '0);
                sink_eop   <= (in_cnt == LAST);
            end else if (sink_ready) begin
                sink_valid <= 1'b0;
            end
        end
    end

    function automatic logic [DATA_W:0] abs_val(
        input logic signed [DATA_W-1:0] v
    );
        logic signed [DATA_W:0] e;
        e = {v[DATA_W-1], v};
        if (v[DATA_W-1]) e = -e;
        return e;
    endfunction

    // Sum of two magnitudes tops out at 2^DATA_W, which fits DATA_W+1 bits
    assign mag  = abs_val(source_real) + abs_val(source_imag);
    assign beat = source_valid && source_ready;

    always_comb begin
        src_next = src_state;
        err      = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        done     = 1'b0;
        unique case (src_state)
            S_WAIT_SOP, S_REPORT: begin
                if (src_state == S_REPORT) src_next = S_WAIT_SOP;
                if (beat) begin
                    if (source_error != 2'b00) begin
                        err = 1'b1;
                    end else if (source_sop) begin
                        start    = 1'b1;
                        src_next = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (beat) begin
                    if (source_error != 2'b00) begin
                        err      = 1'b1;
                        src_next = S_WAIT_SOP;
                    end else if (source_sop) begin
                        err   = 1'b1;
                        start = 1'b1;
                    end else begin
                        step = 1'b1;
                        if (source_eop) begin
                            if (out_cnt == LAST) begin
                                done     = 1'b1;
                                src_next = S_REPORT;
                            end else begin
                                err      = 1'b1;
                                src_next = S_WAIT_SOP;
                            end
                        end
                    end
                end
            end
            default: src_next = S_WAIT_SOP;
        endcase
    end

    // DC and the mirrored upper half never compete; ties keep the lower bin
    assign win = step && out_cnt != '0 && out_cnt < HALF && mag > max_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_state    <= S_WAIT_SOP;
            source_ready <= 1'b0;
            out_cnt      <= '0;
            max_bin      <= '0;
            max_mag      <= '0;
            peak_bin     <= '0;
            peak_mag     <= '0;
            peak_valid   <= 1'b0;
            seq_error    <= 1'b0;
        end else begin
            src_state    <= src_next;
            source_ready <= 1'b1;
            peak_valid   <= done;
            seq_error    <= err;
            if (start) begin
                out_cnt <= PTS_W'(1);
                max_bin <= '0;
                max_mag <= '0;
            end else if (step) begin
                out_cnt <= out_cnt + 1'b1;
                if (win) begin
                    max_bin <= out_cnt;
                    max_mag <= mag;
                end
            end
            if (done) begin
                peak_bin <= max_bin;
                peak_mag <= max_mag;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer at FFT_POINTS = 16: sink framing,
// backpressure, drain on disable, peak search and error framing.
module tb_fft_frame_sequencer;

    localparam int DW = 14;
    localparam int NP = 16;
    localparam int PW = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic signed [DW-1:0] sample_in;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 sink_valid;
    logic                 sink_sop;
    logic                 sink_eop;
    logic signed [DW-1:0] sink_real;
    logic signed [DW-1:0] sink_imag;
    logic                 inverse;
    logic [PW-1:0]        fft_pts;
    logic [1:0]           sink_error;
    logic                 sink_ready;
    logic                 source_valid;
    logic                 source_sop;
    logic                 source_eop;
    logic signed [DW-1:0] source_real;
    logic signed [DW-1:0] source_imag;
    logic [1:0]           source_error;
    logic                 source_ready;
    logic [PW-1:0]        peak_bin;
    logic [DW:0]          peak_mag;
    logic                 peak_valid;
    logic                 seq_error;

    fft_frame_sequencer #(
        .DATA_W(DW), .FFT_POINTS(NP), .PTS_W(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sink_valid(sink_valid),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag),
        .inverse(inverse), .fft_pts(fft_pts), .sink_error(sink_error),
        .sink_ready(sink_ready), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_real(source_real), .source_imag(source_imag),
        .source_error(source_error), .source_ready(source_ready),
        .peak_bin(peak_bin), .peak_mag(peak_mag),
        .peak_valid(peak_valid), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sink-side reference: expected framing and in-order delivery
    logic signed [DW-1:0] exp_q[$];
    logic signed [DW-1:0] acc_val, h_real;
    logic acc_pend = 1'b0, acc_sop, acc_eop;
    logic stall_pend = 1'b0, h_sop, h_eop;
    int   mcnt = 0;
    int   eop_cnt = 0, pv_cyc = 0, se_cyc = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            acc_pend   = 1'b0;
            stall_pend = 1'b0;
            mcnt       = 0;
            exp_q.delete();
        end else begin
            if (peak_valid) pv_cyc++;
            if (seq_error)  se_cyc++;
            if (acc_pend) begin
                chk("lat_valid", sink_valid, 1);
                chk("lat_real", sink_real, acc_val);
                chk("lat_sop", sink_sop, acc_sop);
                chk("lat_eop", sink_eop, acc_eop);
            end
            if (stall_pend) begin
                chk("hold_real", sink_real, h_real);
                chk("hold_sop", sink_sop, h_sop);
                chk("hold_eop", sink_eop, h_eop);
            end
            if (sink_valid && !sink_ready) begin
                chk("stall_sready", sample_ready, 0);
                stall_pend = 1'b1;
                h_real = sink_real;
                h_sop  = sink_sop;
                h_eop  = sink_eop;
            end else begin
                stall_pend = 1'b0;
            end
            if (sink_valid && sink_ready) begin
                chk("xfer_has_exp", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("xfer_order", sink_real, exp_q.pop_front());
                if (sink_eop) eop_cnt++;
            end
            acc_pend = sample_valid && sample_ready;
            if (acc_pend) begin
                acc_val = sample_in;
                acc_sop = (mcnt == 0);
                acc_eop = (mcnt == NP - 1);
                mcnt    = (mcnt + 1) % NP;
                exp_q.push_back(sample_in);
            end
        end
    end

    task automatic send(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bit ok = 0;
            sample_in    = DW'(first + i);
            sample_valid = 1'b1;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(negedge clk);
                ok = sample_ready;
                @(posedge clk);
                #1;
            end
            if (!ok) chk("send_timeout", 0, 1);
        end
        sample_valid = 1'b0;
    endtask

    logic signed [DW-1:0] re_t[32], im_t[32];
    logic                 sop_t[32], eop_t[32];
    logic [1:0]           err_t[32];

    task automatic clr_tab();
        for (int i = 0; i < 32; i++) begin
            re_t[i] = '0; im_t[i] = '0;
            sop_t[i] = 1'b0; eop_t[i] = 1'b0; err_t[i] = 2'b00;
        end
    endtask

    task automatic run_src(input int n);
        for (int i = 0; i < n; i++) begin
            source_valid = 1'b1;
            source_sop   = sop_t[i];
            source_eop   = eop_t[i];
            source_real  = re_t[i];
            source_imag  = im_t[i];
            source_error = err_t[i];
            @(posedge clk);
            #1;
        end
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        source_error = 2'b00;
    endtask

    task automatic check_rst();
        chk("rst_sready", sample_ready, 0);
        chk("rst_svalid", sink_valid, 0);
        chk("rst_sop", sink_sop, 0);
        chk("rst_eop", sink_eop, 0);
        chk("rst_real", sink_real, 0);
        chk("rst_imag", sink_imag, 0);
        chk("rst_inverse", inverse, 0);
        chk("rst_fft_pts", fft_pts, NP);
        chk("rst_sink_err", sink_error, 0);
        chk("rst_src_ready", source_ready, 0);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_seq_error", seq_error, 0);
    endtask

    task automatic release_rst();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_src_ready0", source_ready, 0);
        step(1);
        chk("rel_src_ready1", source_ready, 1);
    endtask

    int e0, p0, s0, found;

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0;
        sample_in = '0; sample_valid = 1'b0; sink_ready = 1'b1;
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
        source_real = '0; source_imag = '0; source_error = 2'b00;
        clr_tab();
        #12;
        check_rst();
        step(1);
        release_rst();

        // Two full-rate frames
        enable = 1'b1;
        e0 = eop_cnt;
        send(0, 32);
        step(2);
        chk("two_frames_eop", eop_cnt - e0, 2);
        chk("two_frames_q", exp_q.size(), 0);

        // Three-cycle sink stall while sample 5 is held
        found = 0;
        fork
            send(0, 16);
            begin
                for (int n = 0; n < 100 && found == 0; n++) begin
                    @(posedge clk);
                    #1;
                    if (sink_valid && sink_real == 5) found = 1;
                end
                chk("stall_found", found, 1);
                sink_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", sample_ready, 0);
                    chk("stall_real", sink_real, 5);
                end
                step(1);
                sink_ready = 1'b1;
            end
        join
        step(2);
        chk("stall_q", exp_q.size(), 0);

        // Peak search: DC and mirrored bins excluded
        clr_tab();
        sop_t[0] = 1; eop_t[15] = 1;
        re_t[0] = 8000; re_t[5] = -200; im_t[5] = 100; re_t[12] = 300;
        p0 = pv_cyc; s0 = se_cyc;
        run_src(16);
        @(negedge clk);
        chk("pk_valid", peak_valid, 1);
        chk("pk_bin", peak_bin, 5);
        chk("pk_mag", peak_mag, 300);
        @(negedge clk);
        chk("pk_pulse", peak_valid, 0);
        chk("pk_hold", peak_bin, 5);
        step(1);
        chk("pk_pv_cnt", pv_cyc - p0, 1);
        chk("pk_se_cnt", se_cyc - s0, 0);

        // All-zero frame reports bin 0
        clr_tab();
        sop_t[0] = 1; eop_t[15] = 1;
        run_src(16);
        @(negedge clk);
        chk("zero_valid", peak_valid, 1);
        chk("zero_bin", peak_bin, 0);
        chk("zero_mag", peak_mag, 0);
        step(1);

        // SOP at out_cnt 9 restarts; new frame has -8192 tie and a 16382 mirror
        clr_tab();
        sop_t[0] = 1;
        re_t[4] = 8191; im_t[4] = 8191;
        sop_t[9] = 1;
        re_t[12] = -8192;
        re_t[16] = 4000; im_t[16] = 4192;
        re_t[17] = 8191; im_t[17] = 8191;
        eop_t[24] = 1;
        p0 = pv_cyc; s0 = se_cyc;
        run_src(25);
        @(negedge clk);
        chk("rs_valid", peak_valid, 1);
        chk("rs_bin", peak_bin, 3);
        chk("rs_mag", peak_mag, 8192);
        step(2);
        chk("rs_pv_cnt", pv_cyc - p0, 1);
        chk("rs_se_cnt", se_cyc - s0, 1);

        // Short frame: EOP at out_cnt 9
        clr_tab();
        sop_t[0] = 1; eop_t[9] = 1; re_t[3] = 100;
        p0 = pv_cyc; s0 = se_cyc;
        run_src(10);
        step(2);
        chk("short_pv_cnt", pv_cyc - p0, 0);
        chk("short_se_cnt", se_cyc - s0, 1);
        chk("short_hold", peak_bin, 3);

        // Core error mid-frame; the rest of the frame is ignored
        clr_tab();
        sop_t[0] = 1; err_t[4] = 2'b01; eop_t[15] = 1; re_t[2] = 50;
        p0 = pv_cyc; s0 = se_cyc;
        run_src(16);
        step(2);
        chk("err_pv_cnt", pv_cyc - p0, 0);
        chk("err_se_cnt", se_cyc - s0, 1);

        // Reset mid-frame
        e0 = eop_cnt;
        send(0, 5);
        sample_in = 77; sample_valid = 1'b1;
        step(1);
        reset_n = 1'b0;
        #2;
        check_rst();
        sample_valid = 1'b0; enable = 1'b0;
        step(2);
        chk("rst_no_eop", eop_cnt - e0, 0);
        release_rst();

        // Disable mid-frame: drain to EOP, then idle
        enable = 1'b1;
        e0 = eop_cnt;
        send(0, 8);
        enable = 1'b0;
        send(8, 8);
        step(2);
        chk("drain_eop", eop_cnt - e0, 1);
        sample_in = 99; sample_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_sready", sample_ready, 0);
        end
        step(1);
        sample_valid = 1'b0;
        chk("drain_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sits between the audio sample source and the FFT core.
- Frames the incoming real sample stream into FFT_POINTS-long packets with SOP/EOP, honouring the core's sink_ready backpressure.
- Drives the core's static controls (inverse, fft_pts, sink_error).
- Scans each output frame for the strongest bin and reports the peak bin and magnitude per frame, for note detection.

Parameters:
- DATA_W, 14, sample and FFT data width (signed).
- FFT_POINTS, 1024, transform length; power of two, ≥ 8.
- PTS_W, 11, width of fft_pts and the bin counters; must satisfy 2^(PTS_W-1) ≥ FFT_POINTS.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; stop takes effect only at a frame boundary.
- sample_in  in  DATA_W  signed input sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  sample is accepted when sample_valid && sample_ready.
- sink_valid  out  1  FFT sink valid.
- sink_sop  out  1  first sample of a frame.
- sink_eop  out  1  last sample of a frame.
- sink_real  out  DATA_W  FFT sink real part.
- sink_imag  out  DATA_W  FFT sink imaginary part; always 0.
- inverse  out  1  always 0 (forward FFT).
- fft_pts  out  PTS_W  constant FFT_POINTS.
- sink_error  out  2  always 0.
- sink_ready  in  1  FFT core can accept data.
- source_valid  in  1  FFT output valid.
- source_sop  in  1  FFT output bin 0.
- source_eop  in  1  FFT output last bin.
- source_real  in  DATA_W  signed output real part.
- source_imag  in  DATA_W  signed output imaginary part.
- source_error  in  2  FFT error status.
- source_ready  out  1  backpressure to the FFT source.
- peak_bin  out  PTS_W  index of the strongest bin in the last frame.
- peak_mag  out  DATA_W+1  magnitude of that bin.
- peak_valid  out  1  one-cycle pulse when peak_bin/peak_mag update.
- seq_error  out  1  one-cycle pulse on a framing or core error.

Behaviour:
Reset:
- All outputs are 0, except fft_pts = FFT_POINTS.
- source_ready is 0 while reset_n is low and 1 from the first clk after release.
- Sink FSM enters IDLE; in_cnt = 0; source FSM enters WAIT_SOP; accumulators are cleared.
- Reset mid-frame discards the partial frame; no EOP is emitted.

Sink FSM, states IDLE, STREAM, DRAIN:
- IDLE: sample_ready = 0. Goes to STREAM when enable = 1.
- STREAM and DRAIN: one-entry output register; sample_ready = !sink_valid || sink_ready (combinational).
- On accept, the next cycle has:
  - sink_valid = 1
  - sink_real = sample_in, sink_imag = 0
  - sink_sop = (in_cnt == 0)
  - sink_eop = (in_cnt == FFT_POINTS-1)
  - in_cnt incremented, wrapping to 0 after FFT_POINTS-1.
- sink_valid is cleared when sink_ready = 1 and there is no new accept in the same cycle.
- While sink_valid && !sink_ready, sink_real, sink_sop and sink_eop hold stable.
- Latency from sample accept to sink_valid is 1 cycle; a full-rate stream is sustained when sink_ready = 1.
- STREAM → DRAIN when enable = 0 and in_cnt ≠ 0; STREAM → IDLE when enable = 0 and in_cnt = 0 and the register is empty.
- DRAIN: continues accepting samples until the EOP sample transfers, then goes to IDLE. Re-asserting enable in DRAIN returns to STREAM.

Source FSM, states WAIT_SOP, COLLECT, REPORT:
- Bins are consumed on source_valid && source_ready.
- Magnitude: mag = |source_real| + |source_imag|, computed unsigned at DATA_W+1 bits; -2^(DATA_W-1) maps to 2^(DATA_W-1) with no overflow.
- WAIT_SOP:
  - A beat with source_sop sets out_cnt = 1 and max = 0, then goes to COLLECT.
  - Non-SOP beats are ignored.
- COLLECT:
  - Each beat increments out_cnt.
  - Only bins 1 .. FFT_POINTS/2-1 are compared: DC and the mirrored half are excluded.
  - Update on strictly greater mag, so the lowest bin wins ties.
  - On source_eop, goes to REPORT.
- REPORT: for 1 cycle, peak_valid = 1 with peak_bin/peak_mag = max, then goes to WAIT_SOP. peak_bin/peak_mag hold until the next report.
- If no bin exceeds 0, report peak_bin = 0 and peak_mag = 0.
- seq_error pulses for 1 cycle, with no report, on any of:
  - source_sop in COLLECT: this restarts the frame, i.e. acts as a new SOP.
  - source_eop with out_cnt ≠ FFT_POINTS-1: goes to WAIT_SOP.
  - source_error ≠ 0 on any valid beat: goes to WAIT_SOP.

Test Plan:
1. Reset check, FFT_POINTS = 16: assert reset_n = 0 mid-stream → all outputs 0, fft_pts = 16, source_ready = 0; release → source_ready = 1 the next cycle.
2. enable = 1, sink_ready = 1, 32 consecutive samples 0..31 → two frames; sink_sop on samples 0 and 16, sink_eop on 15 and 31; each sink_real equals its sample 1 cycle after accept.
3. sink_ready = 0 for 3 cycles at sample 5 → sample_ready = 0 for those cycles, sink_real = 5 held stable; no sample is lost or duplicated.
4. Source frame of 16 bins:
   - bin 0 = (8000, 0); bin 5 = (-200, 100); bin 12 = (300, 0); others 0.
   - Required: peak_valid one cycle after eop, peak_bin = 5, peak_mag = 300, because bin 12 is in the mirrored half and bin 0 is DC.
5. enable dropped after sample 7 of 16 → the remaining 8 samples are still accepted, eop is emitted on sample 15, then sample_ready = 0 (IDLE).
6. source_sop again at out_cnt = 9 → seq_error pulse, no peak_valid; the next full 16-bin frame reports normally.
